// File: rtl/rf_pkg.sv
// Shared types and helpers for the multiport register file and its scoreboard.
package rf_pkg;

   typedef enum logic {RF_CLEAR, RF_RUN} rf_state_e;

   localparam int RF_XLEN  = 32;
   localparam int RF_NREGS = 32;
   localparam int MAX_WR   = 2;

   // Returns the highest-numbered write port whose hit bit is set, or -1.
   function automatic int wr_sel(input logic [MAX_WR-1:0] hit);
      int sel;
      sel = -1;
      for (int i = 0; i < MAX_WR; i++) begin
         if (hit[i]) sel = i;
      end
      return sel;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write bits: issue sets, writeback clears, and the
// read-side lookup masks a register that is being written this cycle.
module rf_scoreboard #(
   parameter int NREGS    = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ready,
   input  logic [NUM_WR-1:0]            wr_act,
   input  logic [NUM_WR-1:0][AW-1:0]    wr_addr,
   input  logic                         set_en,
   input  logic [AW-1:0]                set_addr,
   input  logic [NUM_RD-1:0][AW-1:0]    rd_addr,
   output logic [NUM_RD-1:0]            rd_pending
);

   logic [NREGS-1:0]  pending;
   logic [NREGS-1:0]  pending_n;
   logic [NUM_RD-1:0] rd_fwd;

   // Set is applied after the clears so a newly issued producer wins
   // over one retiring to the same register in the same cycle.
   always_comb begin
      pending_n = pending;
      for (int i = 0; i < NUM_WR; i++) begin
         if (wr_act[i]) pending_n[wr_addr[i]] = 1'b0;
      end
      if (ready && set_en && !(ZERO_REG != 0 && set_addr == '0))
         pending_n[set_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) pending <= '0;
      else     pending <= pending_n;
   end

   always_comb begin
      rd_fwd = '0;
      for (int j = 0; j < NUM_RD; j++) begin
         for (int i = 0; i < NUM_WR; i++) begin
            if (wr_act[i] && wr_addr[i] == rd_addr[j]) rd_fwd[j] = 1'b1;
         end
         rd_pending[j] = ready & pending[rd_addr[j]] & ~rd_fwd[j];
      end
   end

endmodule

// File: rtl/multiport_register_file.sv
// Parametrised decode-stage register file: NUM_RD read ports, NUM_WR write
// ports with write-through forwarding, pending scoreboard and post-reset clear.
module multiport_register_file
   import rf_pkg::*;
#(
   parameter int XLEN     = RF_XLEN,
   parameter int NREGS    = RF_NREGS,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_WR-1:0]             wr_en,
   input  logic [NUM_WR-1:0][AW-1:0]     wr_addr,
   input  logic [NUM_WR-1:0][XLEN-1:0]   wr_data,
   input  logic [NUM_RD-1:0][AW-1:0]     rd_addr,
   output logic [NUM_RD-1:0][XLEN-1:0]   rd_data,
   output logic [NUM_RD-1:0]             rd_pending,
   input  logic                          sb_set_en,
   input  logic [AW-1:0]                 sb_set_addr,
   output logic                          ready
);

   rf_state_e state, state_n;
   logic [AW-1:0] clr_idx;

   logic [XLEN-1:0] mem [NREGS];

   logic [NUM_WR-1:0]                 wr_act;
   logic [NUM_WR-1:0]                 mem_we;
   logic [NUM_WR-1:0][AW-1:0]         mem_wa;
   logic [NUM_WR-1:0][XLEN-1:0]       mem_wd;
   logic [NUM_RD-1:0][MAX_WR-1:0]     rd_hit;

   assign ready = (state == RF_RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RF_CLEAR;
         clr_idx <= '0;
      end else begin
         state <= state_n;
         if (state == RF_CLEAR) clr_idx <= clr_idx + AW'(1);
      end
   end

   always_comb begin
      state_n = state;
      if (state == RF_CLEAR && clr_idx == AW'(NREGS - 1)) state_n = RF_RUN;
   end

   always_comb begin
      for (int i = 0; i < NUM_WR; i++) begin
         wr_act[i] = ready && wr_en[i] && (ZERO_REG == 0 || wr_addr[i] != '0);
      end
   end

   // Port 0 doubles as the clear port so the array keeps one write path per port.
   always_comb begin
      mem_we = wr_act;
      mem_wa = wr_addr;
      mem_wd = wr_data;
      if (!ready) begin
         mem_we[0] = 1'b1;
         mem_wa[0] = clr_idx;
         mem_wd[0] = '0;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_WR; i++) begin
         if (mem_we[i]) mem[mem_wa[i]] <= mem_wd[i];
      end
   end

   always_comb begin
      rd_hit = '0;
      for (int j = 0; j < NUM_RD; j++) begin
         for (int i = 0; i < NUM_WR; i++) begin
            rd_hit[j][i] = wr_act[i] && wr_addr[i] == rd_addr[j];
         end
      end
   end

   always_comb begin
      for (int j = 0; j < NUM_RD; j++) begin
         rd_data[j] = mem[rd_addr[j]];
         for (int i = 0; i < NUM_WR; i++) begin
            if (i == wr_sel(rd_hit[j])) rd_data[j] = wr_data[i];
         end
         if (!ready || (ZERO_REG != 0 && rd_addr[j] == '0)) rd_data[j] = '0;
      end
   end

   rf_scoreboard #(
      .NREGS    (NREGS),
      .NUM_RD   (NUM_RD),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .ready      (ready),
      .wr_act     (wr_act),
      .wr_addr    (wr_addr),
      .set_en     (sb_set_en),
      .set_addr   (sb_set_addr),
      .rd_addr    (rd_addr),
      .rd_pending (rd_pending)
   );

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed self-checking bench for multiport_register_file (2 read, 2 write ports).
module tb_multiport_register_file;

   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int NUM_RD = 2;
   localparam int NUM_WR = 2;
   localparam int AW     = 5;

   logic clk = 1'b0;
   logic rst;
   logic [NUM_WR-1:0]             wr_en;
   logic [NUM_WR-1:0][AW-1:0]     wr_addr;
   logic [NUM_WR-1:0][XLEN-1:0]   wr_data;
   logic [NUM_RD-1:0][AW-1:0]     rd_addr;
   logic [NUM_RD-1:0][XLEN-1:0]   rd_data;
   logic [NUM_RD-1:0]             rd_pending;
   logic                          sb_set_en;
   logic [AW-1:0]                 sb_set_addr;
   logic                          ready;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   multiport_register_file #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .NUM_RD   (NUM_RD),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_pending  (rd_pending),
      .sb_set_en   (sb_set_en),
      .sb_set_addr (sb_set_addr),
      .ready       (ready)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         fails++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int port, input logic en,
                                input logic [AW-1:0] addr, input logic [XLEN-1:0] data);
      wr_en[port]   = en;
      wr_addr[port] = addr;
      wr_data[port] = data;
   endtask

   task automatic idleInputs();
      wr_en     = '0;
      sb_set_en = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Counts edges until ready rises; a stuck ready shows up as a wrong count.
   task automatic waitReady(input string tag);
      int n;
      n = 0;
      while (!ready && n < 100) begin
         tick();
         n++;
      end
      checkOutput(tag, 32'(n), 32'd32);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      wr_en = '0; wr_addr = '0; wr_data = '0;
      rd_addr = '0; sb_set_en = 1'b0; sb_set_addr = '0;
      @(negedge clk);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("rst_ready", 32'(ready), 32'd0);
      checkOutput("rst_rd_data", rd_data[0], 32'd0);
      checkOutput("rst_rd_pending", 32'(rd_pending), 32'd0);

      // Writes and issues during the clear must be ignored
      applyStimulus(0, 1'b1, 5'd3, 32'hAAAA_5555);
      sb_set_en = 1'b1; sb_set_addr = 5'd3; rd_addr[0] = 5'd3;
      #1;
      checkOutput("clr_rd_zero", rd_data[0], 32'd0);
      waitReady("clear_len");
      idleInputs();

      for (int a = 0; a < NREGS; a++) begin
         rd_addr[0] = AW'(a);
         rd_addr[1] = AW'(NREGS - 1 - a);
         #1;
         checkOutput($sformatf("zero_p0_x%0d", a), rd_data[0], 32'd0);
         checkOutput($sformatf("zero_p1_x%0d", NREGS - 1 - a), rd_data[1], 32'd0);
         checkOutput($sformatf("nopend_x%0d", a), 32'(rd_pending[0]), 32'd0);
      end

      applyStimulus(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
      rd_addr[0] = 5'd5; rd_addr[1] = 5'd6;
      #1;
      checkOutput("fwd_x5", rd_data[0], 32'hDEAD_BEEF);
      checkOutput("nofwd_x6", rd_data[1], 32'd0);
      tick(); idleInputs(); #1;
      checkOutput("arr_x5", rd_data[0], 32'hDEAD_BEEF);

      applyStimulus(0, 1'b1, 5'd0, 32'h0000_1234);
      rd_addr[0] = 5'd0; rd_addr[1] = 5'd0;
      sb_set_en = 1'b1; sb_set_addr = 5'd0;
      #1;
      checkOutput("x0_fwd_p0", rd_data[0], 32'd0);
      checkOutput("x0_fwd_p1", rd_data[1], 32'd0);
      tick(); idleInputs(); #1;
      checkOutput("x0_arr_p0", rd_data[0], 32'd0);
      checkOutput("x0_arr_p1", rd_data[1], 32'd0);
      checkOutput("x0_pending", 32'(rd_pending), 32'd0);

      applyStimulus(0, 1'b1, 5'd7, 32'h11);
      applyStimulus(1, 1'b1, 5'd7, 32'h22);
      rd_addr[0] = 5'd7; rd_addr[1] = 5'd5;
      #1;
      checkOutput("dual_fwd_x7", rd_data[0], 32'h22);
      checkOutput("dual_other_x5", rd_data[1], 32'hDEAD_BEEF);
      tick(); idleInputs(); #1;
      checkOutput("dual_arr_x7", rd_data[0], 32'h22);

      sb_set_en = 1'b1; sb_set_addr = 5'd9;
      rd_addr[0] = 5'd9; rd_addr[1] = 5'd8;
      #1;
      checkOutput("sb_set_same_cycle", 32'(rd_pending[0]), 32'd0);
      tick(); idleInputs(); #1;
      checkOutput("sb_pend_x9", 32'(rd_pending[0]), 32'd1);
      checkOutput("sb_nopend_x8", 32'(rd_pending[1]), 32'd0);
      tick(); #1;
      checkOutput("sb_hold_x9", 32'(rd_pending[0]), 32'd1);
      applyStimulus(1, 1'b1, 5'd9, 32'h99);
      #1;
      checkOutput("wb_pend_x9", 32'(rd_pending[0]), 32'd0);
      checkOutput("wb_fwd_x9", rd_data[0], 32'h99);
      tick(); idleInputs(); #1;
      checkOutput("wb_clr_x9", 32'(rd_pending[0]), 32'd0);
      checkOutput("wb_arr_x9", rd_data[0], 32'h99);
      sb_set_en = 1'b1; sb_set_addr = 5'd9;
      applyStimulus(0, 1'b1, 5'd9, 32'h55);
      #1;
      checkOutput("setwr_mask_x9", 32'(rd_pending[0]), 32'd0);
      checkOutput("setwr_fwd_x9", rd_data[0], 32'h55);
      tick(); idleInputs(); #1;
      checkOutput("setwr_pend_x9", 32'(rd_pending[0]), 32'd1);
      checkOutput("setwr_arr_x9", rd_data[0], 32'h55);

      // Reset from RUN, then a second reset ten entries into the clear
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checkOutput("run_rst_ready", 32'(ready), 32'd0);
      applyStimulus(0, 1'b1, 5'd5, 32'h0000_0BAD);
      sb_set_en = 1'b1; sb_set_addr = 5'd9;
      for (int k = 0; k < 10; k++) tick();
      #1;
      checkOutput("midclr_ready", 32'(ready), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      waitReady("midclr_len");
      idleInputs();
      rd_addr[0] = 5'd5; rd_addr[1] = 5'd7;
      #1;
      checkOutput("post_clr_x5", rd_data[0], 32'd0);
      checkOutput("post_clr_x7", rd_data[1], 32'd0);
      rd_addr[0] = 5'd9; rd_addr[1] = 5'd3;
      #1;
      checkOutput("post_clr_x9", rd_data[0], 32'd0);
      checkOutput("post_clr_pend_x9", 32'(rd_pending[0]), 32'd0);
      checkOutput("post_clr_x3", rd_data[1], 32'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised integer register file for the decode stage, replacing the fixed 2-read/1-write, 32×32 array. Provides NUM_RD combinational read ports and NUM_WR write ports with same-cycle write-through forwarding. Also provides a per-register pending-write scoreboard for hazard detection and a post-reset clear sequencer, so the array stays RAM-inferable while still coming up zeroed. Sits between the decoder (read/issue side) and the writeback stage (write side).

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥4)
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 1, number of write ports (1..2)
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and never pending
- localparam AW = $clog2(NREGS)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR×AW  write addresses, packed [NUM_WR-1:0][AW-1:0]
- wr_data  in  NUM_WR×XLEN  write data
- rd_addr  in  NUM_RD×AW  read addresses
- rd_data  out  NUM_RD×XLEN  read data, combinational
- rd_pending  out  NUM_RD  register has an outstanding producer, combinational
- sb_set_en  in  1  mark sb_set_addr pending (instruction issued with destination)
- sb_set_addr  in  AW  destination being issued
- ready  out  1  high once the clear sequence has completed

## Operation
- Clear FSM states: CLEAR, RUN.
  - rst high: state←CLEAR, clr_idx←0, all pending bits←0.
  - In CLEAR: entry clr_idx←0 every cycle, clr_idx increments. At clr_idx==NREGS-1, go to RUN.
  - RUN holds until the next rst.
- ready = (state==RUN). While not ready:
  - wr_en and sb_set_en are ignored.
  - rd_data = 0 and rd_pending = 0 on all ports.
- Write (RUN only): each wr_en[i] with wr_addr[i]≠0 (or any address when ZERO_REG=0) writes entry wr_addr[i] at the edge.
  - Two ports writing the same address in one cycle: the higher port index wins.
- Read port j: if any active write targets rd_addr[j] this cycle, forward that port's wr_data (same priority rule). Otherwise return the array entry.
  - ZERO_REG=1 and rd_addr[j]==0: forced to 0, which overrides forwarding.
- Scoreboard, one bit per register:
  - Any active write clears pending[wr_addr[i]].
  - sb_set_en sets pending[sb_set_addr].
  - Set and clear of the same address in one cycle: set wins, because the new producer is younger than the retiring one.
  - sb_set_addr==0 with ZERO_REG=1: ignored.
- rd_pending[j] = pending[rd_addr[j]] & ~(active write to rd_addr[j] this cycle). A consumer reading in the writeback cycle therefore sees valid forwarded data and no stall.

## Timing
- Reset values: ready=0, all pending=0, state=CLEAR, clr_idx=0. rd_data and rd_pending are 0 while not ready.
- rst sampled high at edge E0; edges E1..E_NREGS clear entries 0..NREGS-1; ready goes high after E_NREGS. Clear latency is NREGS cycles.
- rst asserted mid-clear or in RUN restarts the sequence from entry 0 and drops ready in the cycle after the edge.
- Array write and pending update: visible to reads one edge after wr_en/sb_set_en. Forwarded data is visible in the same cycle.
- No handshake backpressure; the caller must not issue until ready.

## Structure
- Shared package rf_pkg:
  - rf_state_e enum {RF_CLEAR, RF_RUN}
  - default XLEN/NREGS constants
  - function for write-port priority selection (address match → port index)
- One natural sub-module, rf_scoreboard: pending bit vector with set/clear/priority logic and rd_pending lookup. Parametrised on NREGS, NUM_RD, NUM_WR, ZERO_REG.
- The array stays a plain unpacked memory with no reset, written only through the single clear/write mux.

## Test plan
- Reset then idle: ready low for exactly 32 cycles after rst deasserts (NREGS=32); every register reads 0 afterwards.
- Write x5=0xDEADBEEF while reading x5 in the same cycle → rd_data=0xDEADBEEF that cycle; next cycle reads 0xDEADBEEF from the array.
- Write x0=0x1234 and read x0 on both ports → rd_data=0 now and later. sb_set_addr=0 → rd_pending stays 0.
- NUM_WR=2, both ports write x7 (0x11 port0, 0x22 port1) → forwarded and stored value is 0x22.
- sb_set x9, then a later write x9 → rd_pending(x9)=1 until the write cycle, where it reads 0 with forwarded data. Same-cycle set+write of x9 leaves pending=1.
- Assert rst for one cycle at clr_idx=10 mid-clear → ready stays low another 32 cycles. A wr_en during clear does not alter post-clear contents (reads 0).
